// File: rtl/pipe_mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access sequencer.
package pipe_mem_pkg;

    localparam int DATA_W      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_mem_access_ctrl_if.sv
// Data-memory request bus. The controller drives it through master,
// the memory through slave.
interface pipe_mem_access_ctrl_if;
    import pipe_mem_pkg::*;

    logic              dreq;
    logic              dwe;
    logic [DATA_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic              dready;
    logic [DATA_W-1:0] drdata;

    modport master (output dreq, dwe, daddr, dwdata, input dready, drdata);
    modport slave  (input dreq, dwe, daddr, dwdata, output dready, drdata);
endinterface

// File: rtl/pipe_mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    // count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                 cnt <= '0;
        else if (clear)            cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_mem_access_ctrl.sv
// MEM-stage sequencer: turns EX/MEM load/store controls into a req/ready
// access, stalls the pipe while the access is outstanding and holds the
// load result while an external stall keeps the instruction in MEM.
// Optional: MEM_TIMEOUT_EN adds a WAIT watchdog that fakes a completion
// and pulses merr after TIMEOUT_CYCLES wait cycles.
module pipe_mem_access_ctrl
    import pipe_mem_pkg::*;
#(
    parameter int STAT_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   mm2reg,
    input  logic                   mwmem,
    input  logic [DATA_W-1:0]      malu,
    input  logic [DATA_W-1:0]      mb,
    input  logic                   ext_stall,
    pipe_mem_access_ctrl_if.master mem,
    output logic [DATA_W-1:0]      mmo,
    output logic                   mstall,
    output logic                   mbubble,
    output logic [STAT_W-1:0]      stall_cnt,
    output logic                   merr
);

    state_t            state, nxt;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_op, dreq, complete, timeout, to_hit, busy;

    assign mem_op = mm2reg | mwmem;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    logic [TO_W-1:0] wait_cnt;

    // counts WAIT cycles; held at zero outside WAIT so entry starts from 0
    sat_counter #(.W(TO_W)) u_wait_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (state == WAIT),
        .clear (state != WAIT),
        .cnt   (wait_cnt)
    );

    assign to_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES));
`else
    assign to_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= nxt;
    end

    // next state, request and completion decode
    always_comb begin
        nxt      = state;
        dreq     = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                dreq = mem_op;
                if (mem_op) begin
                    if (mem.dready) begin
                        complete = 1'b1;
                        if (ext_stall) nxt = DONE;
                    end else begin
                        nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                dreq = 1'b1;
                if (mem.dready) begin
                    complete = 1'b1;
                    nxt      = ext_stall ? DONE : IDLE;
                end else if (to_hit) begin
                    // abandon the access: drop the request and let the pipe go
                    dreq    = 1'b0;
                    timeout = 1'b1;
                    nxt     = ext_stall ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!ext_stall) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // load-data holding register; a timed-out access leaves zero behind
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)         rdata_q <= '0;
        else if (complete) rdata_q <= mem.drdata;
        else if (timeout)  rdata_q <= '0;
    end

    sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (busy),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    assign busy       = dreq & ~mem.dready;
    assign mstall     = busy;
    assign mbubble    = busy;
    assign merr       = timeout;
    assign mem.dreq   = dreq;
    assign mem.dwe    = mwmem & dreq;
    assign mem.daddr  = malu;
    assign mem.dwdata = mb;
    assign mmo        = complete        ? mem.drdata :
                        (state == DONE) ? rdata_q    : '0;

endmodule

// File: doc/pipe_mem_access_ctrl.md
# pipe_mem_access_ctrl

Sequencer for the MEM stage of the five-stage pipeline. It turns the EX/MEM register's memory controls into a req/ready handshake with a variable-latency data memory. While an access is outstanding it stalls the pipeline and inserts a bubble into MEM/WB. It holds completed load data while an external stall keeps the instruction in MEM, so an access is never re-issued.

## Interface
Parameters:
- STAT_W, 32: width of the stall-cycle statistics counter.
- TIMEOUT_CYCLES, 255: WAIT cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- mm2reg  in  1  EX/MEM stage: load.
- mwmem  in  1  EX/MEM stage: store.
- malu  in  32  EX/MEM stage: effective address.
- mb  in  32  EX/MEM stage: store data.
- ext_stall  in  1  stall from elsewhere in the pipeline; holds EX/MEM unchanged.
- dready  in  1  memory: access completes this cycle.
- drdata  in  32  memory read data, valid when dready=1.
- dreq  out  1  memory request.
- dwe  out  1  memory write enable, equal to mwmem & dreq.
- daddr  out  32  equal to malu.
- dwdata  out  32  equal to mb.
- mmo  out  32  load data to MEM/WB.
- mstall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- mbubble  out  1  zero MEM/WB control bits this cycle.
- stall_cnt  out  STAT_W  count of cycles with mstall=1; saturates at all-ones.
- merr  out  1  one-cycle timeout pulse (tied 0 without MEM_TIMEOUT_EN).

## Operation
- mem_op = mm2reg | mwmem. If both are set, the access is treated as a load with dwe=1; this combination is illegal and only needs to be reproducible.
- FSM states are IDLE, WAIT and DONE. Reset state is IDLE.
- IDLE:
  - dreq = mem_op.
  - mem_op & dready: the access completes. Go to DONE if ext_stall=1; otherwise stay in IDLE.
  - mem_op & !dready: go to WAIT.
- WAIT:
  - dreq=1.
  - dready=1: the access completes. Go to DONE if ext_stall=1; otherwise go to IDLE.
- DONE:
  - dreq=0. The access is not re-issued.
  - mmo = rdata_q.
  - ext_stall=0: go to IDLE.
- On completion, drdata is captured into rdata_q.
- mmo = drdata in the completion cycle, rdata_q in DONE, and 0 otherwise.
- busy = dreq & !dready.
- mstall = busy.
- mbubble = busy.
- stall_cnt increments by 1 each cycle with mstall=1 and saturates at all-ones.

## Timing
- Reset values:
  - state IDLE.
  - rdata_q 0.
  - stall_cnt 0.
  - merr 0.
  - All combinational outputs follow from state IDLE with the current inputs.
- Latency: a zero-wait access (dready in the issue cycle) adds 0 stall cycles. An N-cycle memory adds N-1 stall cycles.
- daddr, dwdata and dwe must stay stable while dreq=1. This holds because mstall freezes EX/MEM.
- dready with dreq=0 is ignored.
- dready and ext_stall rising in the same cycle: go to DONE with the data captured.
- Asserting clrn low mid-access (WAIT or DONE) returns to IDLE immediately and drops dreq. The memory must tolerate an abandoned request.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A wait counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without dready, the access completes as a fake completion: merr pulses 1 cycle, mmo=0, dreq drops, and the FSM goes to IDLE (or to DONE with rdata_q=0 if ext_stall=1).
- MEM_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; merr=0.

## Structure
- Package pipe_mem_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the 32-bit data width constant;
  - the default TIMEOUT_CYCLES.
- One sub-module, sat_counter (width parameter, inc, clear, saturate), instantiated for stall_cnt and, when enabled, for the timeout counter.

## Test plan
- Load at 0x100, dready in the issue cycle, drdata=0xDEADBEEF -> mstall never asserted, mmo=0xDEADBEEF that cycle, stall_cnt=0.
- Store at 0x200 with mb=0x12345678, dready after 3 cycles -> dreq=1 and dwe=1 for 3 cycles, mstall=mbubble=1 for 2 cycles, stall_cnt=2.
- Load completes (drdata=0xA5A5A5A5) while ext_stall=1 for 4 cycles -> FSM in DONE, dreq=0 for those 4 cycles, mmo=0xA5A5A5A5 throughout, one request total.
- clrn low while in WAIT -> dreq=0 immediately, state IDLE, rdata_q=0, stall_cnt=0.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, dready never arrives -> merr pulses once on the timeout cycle, mmo=0, mstall deasserts, next instruction proceeds.
- Stall saturation with STAT_W=4: 20 stalled cycles -> stall_cnt holds 15.
